// File: rtl/posit_encoder.sv
// Posit<32,3> field packer: sign, regime k, exponent and fraction in,
// round-to-nearest-even 32-bit posit out over a start/done/received handshake.
module posit_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        received,
  input  logic        sign_out,
  input  logic [5:0]  k_out,
  input  logic [2:0]  exp_out,
  input  logic [31:0] mantissa_out,
  output logic [31:0] p_hold,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUILD,
    S_ROUND,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [5:0]  k_q, k_d;
  logic [2:0]  e_q, e_d;
  logic [31:0] mant_q, mant_d;
  logic [30:0] m_q, m_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [31:0] p_hold_q, p_hold_d;

  logic [6:0]  sh;
  logic [71:0] base;
  logic [71:0] mask;
  logic [71:0] vec;
  logic        k_hi;
  logic        k_lo;
  logic        inc;
  logic [31:0] m_sum;
  logic [30:0] m_fin;
  logic [31:0] word;

  // Regime is left-aligned: positive k fills k+1 ones from the top,
  // negative k shifts the terminating 1 down by -k places.
  always_comb begin
    sh   = 7'd0;
    base = '0;
    mask = '0;
    vec  = '0;
    if (!k_q[5]) begin
      sh   = {1'b0, k_q} + 7'd1;
      base = {1'b0, e_q, mant_q, 36'd0};
      mask = ~({72{1'b1}} >> sh);
      vec  = (base >> sh) | mask;
    end else begin
      sh   = 7'd0 - {k_q[5], k_q};
      base = {1'b1, e_q, mant_q, 36'd0};
      vec  = base >> sh;
    end
  end

  always_comb begin
    k_hi  = !k_q[5] && (k_q >= 6'd30);
    k_lo  = k_q[5] && (k_q <= 6'b100001);
    inc   = guard_q & (sticky_q | m_q[0]);
    m_sum = {1'b0, m_q} + {31'd0, inc};
    m_fin = m_sum[30:0];
    if (k_hi || m_sum[31]) begin
      m_fin = 31'h7FFF_FFFF;
    end else if (k_lo || (m_sum[30:0] == 31'd0)) begin
      m_fin = 31'd1;
    end
    word = {1'b0, m_fin};
    if (sign_q) begin
      word = 32'd0 - word;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    k_d      = k_q;
    e_d      = e_q;
    mant_d   = mant_q;
    m_d      = m_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    p_hold_d = p_hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = sign_out;
          k_d     = k_out;
          e_d     = exp_out;
          mant_d  = mantissa_out;
          state_d = S_BUILD;
        end
      end
      S_BUILD: begin
        m_d      = vec[71:41];
        guard_d  = vec[40];
        sticky_d = |vec[39:0];
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        p_hold_d = word;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (received) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      k_q      <= '0;
      e_q      <= '0;
      mant_q   <= '0;
      m_q      <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      p_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      k_q      <= k_d;
      e_q      <= e_d;
      mant_q   <= mant_d;
      m_q      <= m_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      p_hold_q <= p_hold_d;
    end
  end

  assign p_hold = p_hold_q;
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: directed field vectors with
// hand-derived posit words, handshake hold and mid-operation reset.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        received;
  logic        sign_out;
  logic [5:0]  k_out;
  logic [2:0]  exp_out;
  logic [31:0] mantissa_out;
  logic [31:0] p_hold;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic        seen = 1'b0;

  posit_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .received     (received),
    .sign_out     (sign_out),
    .k_out        (k_out),
    .exp_out      (exp_out),
    .mantissa_out (mantissa_out),
    .p_hold       (p_hold),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got %08h expected none", p_hold);
      end else begin
        chk("p_hold", p_hold, sb.pop_front());
      end
    end
    if (!done) seen = 1'b0;
  end

  // mode 0: ack one cycle; mode 1: received held high; mode 2: no ack
  task automatic encode(input logic s, input int k, input logic [2:0] e,
                        input logic [31:0] m, input logic [31:0] exp,
                        input int mode);
    @(negedge clk);
    sign_out     = s;
    k_out        = 6'(k);
    exp_out      = e;
    mantissa_out = m;
    start        = 1'b1;
    if (mode == 1) received = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start        = 1'b0;
    sign_out     = ~s;
    k_out        = 6'd7;
    exp_out      = 3'd6;
    mantissa_out = 32'h1234_5678;
    @(posedge clk);
    #1 chk("lat_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 chk("lat_done", {31'd0, done}, 32'd1);
    if (mode == 0) begin
      @(negedge clk);
      received = 1'b1;
      @(posedge clk);
      #1 received = 1'b0;
      chk("ack_idle", {31'd0, done}, 32'd0);
    end else if (mode == 1) begin
      @(posedge clk);
      #1 received = 1'b0;
      chk("auto_idle", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int bad;
    logic [31:0] held;
    rst = 1'b1;
    start = 1'b0;
    received = 1'b0;
    sign_out = 1'b0;
    k_out = '0;
    exp_out = '0;
    mantissa_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p_hold", p_hold, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    encode(1'b1, -5, 3'b101, 32'hF000_0000, 32'hFC84_0000, 0);
    encode(1'b0, 0, 3'd0, 32'd0, 32'h4000_0000, 0);
    encode(1'b1, 0, 3'd0, 32'd0, 32'hC000_0000, 0);
    encode(1'b0, 30, 3'd5, 32'hABCD_0000, 32'h7FFF_FFFF, 0);
    encode(1'b1, 30, 3'd0, 32'd0, 32'h8000_0001, 0);
    encode(1'b0, 31, 3'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);
    encode(1'b0, -31, 3'd2, 32'h8000_0000, 32'h0000_0001, 0);
    encode(1'b1, -32, 3'd0, 32'd0, 32'hFFFF_FFFF, 0);
    encode(1'b0, -28, 3'b011, 32'd0, 32'h0000_0006, 0);
    encode(1'b0, -28, 3'b010, 32'd0, 32'h0000_0005, 0);
    encode(1'b0, -27, 3'b010, 32'h8000_0000, 32'h0000_000A, 0);
    encode(1'b0, -27, 3'b010, 32'hC000_0000, 32'h0000_000B, 0);
    encode(1'b0, 2, 3'b011, 32'h8000_0000, 32'h7380_0000, 0);
    encode(1'b0, -1, 3'd0, 32'd0, 32'h2000_0000, 1);
    encode(1'b0, 29, 3'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);

    // held in IDLE after completion
    @(negedge clk);
    chk("idle_hold", p_hold, 32'h7FFF_FFFF);

    // hold without ack, start ignored while done
    encode(1'b1, -5, 3'b101, 32'hF000_0000, 32'hFC84_0000, 2);
    @(negedge clk);
    held = p_hold;
    start = 1'b1;
    k_out = 6'd1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!done || p_hold !== held) bad++;
    end
    start = 1'b0;
    chk("hold_100", bad, 32'd0);
    received = 1'b1;
    @(posedge clk);
    #1 received = 1'b0;
    chk("hold_ack", {31'd0, done}, 32'd0);
    encode(1'b0, 0, 3'd0, 32'd0, 32'h4000_0000, 0);

    // reset while in BUILD
    @(negedge clk);
    sign_out = 1'b1;
    k_out = 6'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_p", p_hold, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_mid_idle", {31'd0, done}, 32'd0);
    encode(1'b1, 0, 3'd0, 32'd0, 32'hC000_0000, 0);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
